// File: rtl/flash_page_writer.sv
// flash_page_writer: SPI NOR page programmer (WREN, PAGE PROGRAM, RDSR poll).
// Accepts a valid/ready byte stream and writes it starting at a 24-bit address,
// splitting at page boundaries. SPI mode 0, MSB first.
// Optional feature macro: FLASH_WRITER_ERASE_EN issues SECTOR ERASE (0x20) before the
// first page of each 4 KB sector touched.
//
// state     | meaning
// IDLE      | waiting for start
// ZERO      | zero-length request, one busy cycle
// WREN      | CS low, shifting 0x06
// GAP       | CS high for CS_GAP_CYCLES, then enter gap_tgt
// SE_CMD    | CS low, shifting 0x20 (erase build only)
// SE_ADDR   | shifting 24-bit sector address (erase build only)
// PP_CMD    | CS low, shifting 0x02
// PP_ADDR   | shifting 24-bit page address
// WAIT_DATA | CS low, SCK low, data_in_ready high
// PP_DATA   | shifting one data byte
// RDSR      | CS low, shifting 0x05
// POLL      | clocking status bytes until WIP=0
// DONE      | done pulse, busy low
module flash_page_writer #(
  parameter int SCK_HALF_PERIOD = 1,
  parameter int PAGE_BITWIDTH   = 8,
  parameter int CS_GAP_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] address,
  input  logic [23:0] length,
  input  logic [7:0]  data_in,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  output logic        busy,
  output logic        done,
  output logic        flash_clk,
  output logic        flash_mosi,
  input  logic        flash_miso,
  output logic        flash_cs
);

  localparam logic [7:0]  HALF_LD   = 8'(SCK_HALF_PERIOD - 1);
  localparam logic [15:0] GAP_LD    = 16'(CS_GAP_CYCLES - 1);
  localparam logic [23:0] PAGE_SIZE = 24'(1) << PAGE_BITWIDTH;
  localparam logic [7:0]  OP_WREN   = 8'h06;
  localparam logic [7:0]  OP_PP     = 8'h02;
  localparam logic [7:0]  OP_RDSR   = 8'h05;
`ifdef FLASH_WRITER_ERASE_EN
  localparam logic [7:0]  OP_SE     = 8'h20;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ZERO, S_WREN, S_GAP,
`ifdef FLASH_WRITER_ERASE_EN
    S_SE_CMD, S_SE_ADDR,
`endif
    S_PP_CMD, S_PP_ADDR, S_WAIT_DATA, S_PP_DATA, S_RDSR, S_POLL, S_DONE
  } state_t;

  state_t      state, state_nx, gap_tgt, gap_val;
  logic        sck, cs, cs_nx, wip_bit;
  logic [7:0]  sr, hcnt, ld_byte;
  logic [2:0]  bit_cnt;
  logic [15:0] gap_cnt;
  logic [1:0]  idx;
  logic [23:0] addr, remaining, page_total, page_left, room, page_bytes;
  logic        shifting, byte_done;
  logic        ld, gap_set, idx_clr, idx_inc, take, page_start, page_dec, page_end;
`ifdef FLASH_WRITER_ERASE_EN
  logic        first_page, erase_done, erase_set, need_erase;
  logic [23:0] sector;
`endif

  function automatic logic [7:0] addr_byte(input logic [23:0] a, input logic [1:0] i);
    case (i)
      2'd0:    return a[23:16];
      2'd1:    return a[15:8];
      default: return a[7:0];
    endcase
  endfunction

  assign shifting = (state == S_WREN) || (state == S_PP_CMD) || (state == S_PP_ADDR) ||
`ifdef FLASH_WRITER_ERASE_EN
                    (state == S_SE_CMD) || (state == S_SE_ADDR) ||
`endif
                    (state == S_PP_DATA) || (state == S_RDSR) || (state == S_POLL);
  assign byte_done  = shifting && (hcnt == 8'd0) && sck && (bit_cnt == 3'd7);
  assign room       = PAGE_SIZE - {{(24-PAGE_BITWIDTH){1'b0}}, addr[PAGE_BITWIDTH-1:0]};
  assign page_bytes = (remaining < room) ? remaining : room;
`ifdef FLASH_WRITER_ERASE_EN
  assign sector     = {addr[23:12], 12'h000};
  assign need_erase = (first_page || (addr[11:0] == 12'h000)) && !erase_done;
`endif

  assign flash_clk     = sck;
  assign flash_cs      = cs;
  assign flash_mosi    = sr[7];
  assign busy          = (state != S_IDLE) && (state != S_DONE);
  assign done          = (state == S_DONE);
  assign data_in_ready = (state == S_WAIT_DATA);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_nx   = state;
    ld         = 1'b0;
    ld_byte    = 8'h00;
    cs_nx      = cs;
    gap_set    = 1'b0;
    gap_val    = S_WREN;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    take       = 1'b0;
    page_start = 1'b0;
    page_dec   = 1'b0;
    page_end   = 1'b0;
`ifdef FLASH_WRITER_ERASE_EN
    erase_set  = 1'b0;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        state_nx = S_IDLE;
        if (start) begin
          take = 1'b1;
          if (length == 24'd0) state_nx = S_ZERO;
          else begin
            state_nx = S_WREN;
            ld       = 1'b1;
            ld_byte  = OP_WREN;
            cs_nx    = 1'b0;
          end
        end
      end
      S_ZERO: state_nx = S_DONE;
      S_WREN: if (byte_done) begin
        cs_nx    = 1'b1;
        state_nx = S_GAP;
        gap_set  = 1'b1;
`ifdef FLASH_WRITER_ERASE_EN
        gap_val  = need_erase ? S_SE_CMD : S_PP_CMD;
`else
        gap_val  = S_PP_CMD;
`endif
      end
      S_GAP: if (gap_cnt == 16'd0) begin
        state_nx = gap_tgt;
        ld       = 1'b1;
        cs_nx    = 1'b0;
        case (gap_tgt)
          S_WREN:   ld_byte = OP_WREN;
          S_RDSR:   ld_byte = OP_RDSR;
`ifdef FLASH_WRITER_ERASE_EN
          S_SE_CMD: ld_byte = OP_SE;
`endif
          default:  ld_byte = OP_PP;
        endcase
      end
`ifdef FLASH_WRITER_ERASE_EN
      S_SE_CMD: if (byte_done) begin
        state_nx = S_SE_ADDR;
        ld       = 1'b1;
        ld_byte  = sector[23:16];
        idx_clr  = 1'b1;
      end
      S_SE_ADDR: if (byte_done) begin
        if (idx == 2'd2) begin
          cs_nx     = 1'b1;
          state_nx  = S_GAP;
          gap_set   = 1'b1;
          gap_val   = S_RDSR;
          erase_set = 1'b1;
        end else begin
          ld      = 1'b1;
          ld_byte = addr_byte(sector, idx + 2'd1);
          idx_inc = 1'b1;
        end
      end
`endif
      S_PP_CMD: if (byte_done) begin
        state_nx = S_PP_ADDR;
        ld       = 1'b1;
        ld_byte  = addr[23:16];
        idx_clr  = 1'b1;
      end
      // after the last address byte CS stays low while data is awaited
      S_PP_ADDR: if (byte_done) begin
        if (idx == 2'd2) begin
          state_nx   = S_WAIT_DATA;
          page_start = 1'b1;
        end else begin
          ld      = 1'b1;
          ld_byte = addr_byte(addr, idx + 2'd1);
          idx_inc = 1'b1;
        end
      end
      S_WAIT_DATA: if (data_in_valid) begin
        state_nx = S_PP_DATA;
        ld       = 1'b1;
        ld_byte  = data_in;
      end
      S_PP_DATA: if (byte_done) begin
        page_dec = 1'b1;
        if (page_left == 24'd1) begin
          page_end = 1'b1;
          cs_nx    = 1'b1;
          state_nx = S_GAP;
          gap_set  = 1'b1;
          gap_val  = S_RDSR;
        end else begin
          state_nx = S_WAIT_DATA;
        end
      end
      S_RDSR: if (byte_done) begin
        state_nx = S_POLL;
        ld       = 1'b1;
      end
      // status bytes keep streaming under one CS until WIP reads 0
      S_POLL: if (byte_done) begin
        if (!wip_bit) begin
          cs_nx = 1'b1;
          if (remaining != 24'd0) begin
            state_nx = S_GAP;
            gap_set  = 1'b1;
            gap_val  = S_WREN;
          end else begin
            state_nx = S_DONE;
          end
        end else begin
          ld = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // SPI bit engine: SCK half-period down-counter, MSB-first shift, MISO sampled on SCK rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs      <= 1'b1;
      sck     <= 1'b0;
      sr      <= 8'h00;
      hcnt    <= 8'h00;
      bit_cnt <= 3'd0;
      wip_bit <= 1'b0;
    end else begin
      cs <= cs_nx;
      if (ld) begin
        sr      <= ld_byte;
        sck     <= 1'b0;
        hcnt    <= HALF_LD;
        bit_cnt <= 3'd0;
      end else if (shifting) begin
        if (hcnt == 8'd0) begin
          hcnt <= HALF_LD;
          if (!sck) begin
            sck     <= 1'b1;
            wip_bit <= flash_miso;
          end else begin
            sck     <= 1'b0;
            sr      <= {sr[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end else begin
          hcnt <= hcnt - 8'd1;
        end
      end
    end
  end

  // CS gap timer and address-byte index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= 16'd0;
      gap_tgt <= S_WREN;
      idx     <= 2'd0;
    end else begin
      if (gap_set) begin
        gap_cnt <= GAP_LD;
        gap_tgt <= gap_val;
      end else if ((state == S_GAP) && (gap_cnt != 16'd0)) begin
        gap_cnt <= gap_cnt - 16'd1;
      end
      if (idx_clr)      idx <= 2'd0;
      else if (idx_inc) idx <= idx + 2'd1;
    end
  end

  // transfer bookkeeping: address wraps naturally at 24 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= 24'd0;
      remaining  <= 24'd0;
      page_total <= 24'd0;
      page_left  <= 24'd0;
    end else begin
      if (take) begin
        addr      <= address;
        remaining <= length;
      end else if (page_end) begin
        addr      <= addr + page_total;
        remaining <= remaining - page_total;
      end
      if (page_start) begin
        page_total <= page_bytes;
        page_left  <= page_bytes;
      end else if (page_dec) begin
        page_left <= page_left - 24'd1;
      end
    end
  end

`ifdef FLASH_WRITER_ERASE_EN
  // tracks whether the current page still needs its sector erased
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_page <= 1'b0;
      erase_done <= 1'b0;
    end else if (take) begin
      first_page <= 1'b1;
      erase_done <= 1'b0;
    end else if (page_end) begin
      first_page <= 1'b0;
      erase_done <= 1'b0;
    end else if (erase_set) begin
      erase_done <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_flash_page_writer.sv
// Directed bench for flash_page_writer with a small SPI flash model that logs MOSI bytes
// per CS frame and returns programmable WIP status.
module tb_flash_page_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] address = 24'd0;
  logic [23:0] length = 24'd0;
  logic [7:0]  data_in = 8'h00;
  logic        data_in_valid = 1'b0;
  logic        data_in_ready, busy, done, flash_clk, flash_mosi, flash_miso, flash_cs;

  int checks = 0;
  int errors = 0;

`ifdef FLASH_WRITER_ERASE_EN
  localparam bit ERASE = 1'b1;
`else
  localparam bit ERASE = 1'b0;
`endif

  always #5 clk = ~clk;

  flash_page_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .address(address), .length(length),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .busy(busy), .done(done), .flash_clk(flash_clk), .flash_mosi(flash_mosi),
    .flash_miso(flash_miso), .flash_cs(flash_cs)
  );

  // flash model
  logic       in_frame = 1'b0;
  logic       cs_prev = 1'b1;
  int         bcnt = 0;
  int         cur_len = 0;
  int         cs_falls = 0;
  int         wip_hold = 0;
  int         done_cnt = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] opcode = 8'h00;
  logic [7:0] log_q[$];
  int         frame_q[$];

  assign flash_miso = in_frame && (opcode == 8'h05) && (bcnt >= 8) && ((bcnt % 8) == 7) &&
                      ((bcnt / 8 - 1) < wip_hold);

  always @(flash_cs or posedge flash_clk) begin
    if (flash_cs !== cs_prev) begin
      if (flash_cs === 1'b0) begin
        in_frame = 1'b1;
        bcnt     = 0;
        cur_len  = 0;
        opcode   = 8'h00;
        cs_falls++;
      end else if (in_frame) begin
        frame_q.push_back(cur_len);
        in_frame = 1'b0;
      end
      cs_prev = flash_cs;
    end else if (flash_clk === 1'b1 && in_frame) begin
      sh = {sh[6:0], flash_mosi};
      bcnt++;
      if ((bcnt % 8) == 0) begin
        log_q.push_back(sh);
        cur_len++;
        if (cur_len == 1) opcode = sh;
      end
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // expected traffic
  logic [7:0] exp_log[$];
  int         exp_frames[$];
  int         exp_len = 0;
  logic [7:0] dbuf[0:15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xb(input logic [7:0] b);
    exp_log.push_back(b);
    exp_len++;
  endtask

  task automatic xe();
    exp_frames.push_back(exp_len);
    exp_len = 0;
  endtask

  task automatic exp_rdsr(input int wip);
    xb(8'h05);
    for (int k = 0; k <= wip; k++) xb(8'h00);
    xe();
  endtask

  task automatic exp_erase(input logic [23:0] sect, input int wip);
    if (ERASE) begin
      xb(8'h06); xe();
      xb(8'h20); xb(sect[23:16]); xb(sect[15:8]); xb(sect[7:0]); xe();
      exp_rdsr(wip);
    end
  endtask

  task automatic exp_page(input logic [23:0] a, input int first, input int n, input int wip);
    xb(8'h06); xe();
    xb(8'h02); xb(a[23:16]); xb(a[15:8]); xb(a[7:0]);
    for (int k = 0; k < n; k++) xb(dbuf[first+k]);
    xe();
    exp_rdsr(wip);
  endtask

  task automatic compare(input string tag, input int lb, input int fb);
    chk({tag, "_nframes"}, frame_q.size() - fb, exp_frames.size());
    for (int k = 0; k < exp_frames.size() && (fb + k) < frame_q.size(); k++)
      chk({tag, "_framelen"}, frame_q[fb+k], exp_frames[k]);
    chk({tag, "_nbytes"}, log_q.size() - lb, exp_log.size());
    for (int k = 0; k < exp_log.size() && (lb + k) < log_q.size(); k++)
      chk({tag, "_mosi"}, {24'd0, log_q[lb+k]}, {24'd0, exp_log[k]});
    exp_log.delete();
    exp_frames.delete();
  endtask

  // drives one transfer, optional stall of 20 waiting cycles before byte stall_at,
  // optional start pulse at cycle poke_at while busy
  task automatic run_xfer(input string tag, input logic [23:0] a, input logic [23:0] n,
                          input int stall_at, input int poke_at);
    int   i, stall_left, cyc, d0;
    logic pend, got;
    i = 0; stall_left = 20; cyc = 0; pend = 1'b0; got = 1'b0; d0 = done_cnt;
    @(negedge clk);
    address = a; length = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0; address = 24'hABCDEF; length = 24'd9;
    while (cyc < 20000) begin
      if (pend) i++;
      if (done === 1'b1) begin
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        got = 1'b1;
        break;
      end
      if (i == stall_at && stall_left > 0) begin
        data_in_valid = 1'b0;
        if (data_in_ready === 1'b1) begin
          stall_left--;
          chk({tag, "_stall_sck"}, flash_clk, 1'b0);
          chk({tag, "_stall_cs"}, flash_cs, 1'b0);
        end
      end else begin
        data_in_valid = (i < n);
        data_in = (i < 16) ? dbuf[i] : 8'h00;
      end
      pend = data_in_valid && data_in_ready;
      cyc++;
      start = (cyc == poke_at);
      @(negedge clk);
    end
    start = 1'b0;
    data_in_valid = 1'b0;
    chk({tag, "_done_seen"}, got, 1'b1);
    chk({tag, "_bytes_taken"}, i, n);
    repeat (5) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_idle_cs"}, flash_cs, 1'b1);
    chk({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    int lb, fb, cyc, cf;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cs", flash_cs, 1'b1);
    chk("rst_sck", flash_clk, 1'b0);
    chk("rst_mosi", flash_mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", data_in_ready, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic 4-byte page write at 0
    wip_hold = 0;
    dbuf[0] = 8'h33; dbuf[1] = 8'h32; dbuf[2] = 8'h31; dbuf[3] = 8'h34;
    lb = log_q.size(); fb = frame_q.size();
    exp_erase(24'h000000, 0);
    exp_page(24'h000000, 0, 4, 0);
    run_xfer("t1", 24'h000000, 24'd4, -1, -1);
    compare("t1", lb, fb);

    // page boundary split at 0x0000FE
    dbuf[0] = 8'hA0; dbuf[1] = 8'hA1; dbuf[2] = 8'hA2; dbuf[3] = 8'hA3;
    lb = log_q.size(); fb = frame_q.size();
    exp_erase(24'h000000, 0);
    exp_page(24'h0000FE, 0, 2, 0);
    exp_page(24'h000100, 2, 2, 0);
    run_xfer("t2", 24'h0000FE, 24'd4, -1, -1);
    compare("t2", lb, fb);

    // WIP held for 3 status bytes; start pulse while busy must be ignored
    wip_hold = 3;
    dbuf[0] = 8'h5A;
    lb = log_q.size(); fb = frame_q.size();
    exp_erase(24'h000000, 3);
    exp_page(24'h000010, 0, 1, 3);
    run_xfer("t3", 24'h000010, 24'd1, -1, 30);
    compare("t3", lb, fb);
    wip_hold = 0;

    // data_in_valid low for 20 waiting cycles mid-page
    dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33;
    lb = log_q.size(); fb = frame_q.size();
    exp_erase(24'h000000, 0);
    exp_page(24'h000200, 0, 3, 0);
    run_xfer("t4", 24'h000200, 24'd3, 1, -1);
    compare("t4", lb, fb);

    // zero-length request
    cf = cs_falls;
    @(negedge clk);
    address = 24'h000123; length = 24'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_busy_c1", busy, 1'b1);
    chk("t5_done_c1", done, 1'b0);
    @(negedge clk);
    chk("t5_done_c2", done, 1'b1);
    chk("t5_busy_c2", busy, 1'b0);
    @(negedge clk);
    chk("t5_done_c3", done, 1'b0);
    chk("t5_cs_falls", cs_falls - cf, 0);

    // asynchronous reset during PP_DATA
    @(negedge clk);
    address = 24'h000300; length = 24'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; data_in = 8'h9C; data_in_valid = 1'b1;
    cyc = 0;
    while (data_in_ready !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_ready_seen", data_in_ready, 1'b1);
    @(negedge clk);
    data_in_valid = 1'b0;
    chk("t6_ready_drop", data_in_ready, 1'b0);
    cyc = 0;
    while (flash_clk !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_sck_high", flash_clk, 1'b1);
    chk("t6_cs_low", flash_cs, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_cs", flash_cs, 1'b1);
    chk("t6_rst_sck", flash_clk, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_ready", data_in_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dbuf[0] = 8'h77;
    lb = log_q.size(); fb = frame_q.size();
    exp_erase(24'h000000, 0);
    exp_page(24'h000400, 0, 1, 0);
    run_xfer("t6b", 24'h000400, 24'd1, -1, -1);
    compare("t6b", lb, fb);

    // transfer straddling a 4 KB sector boundary
    dbuf[0] = 8'hB0; dbuf[1] = 8'hB1;
    lb = log_q.size(); fb = frame_q.size();
    exp_erase(24'h000000, 0);
    exp_page(24'h000FFF, 0, 1, 0);
    exp_erase(24'h001000, 0);
    exp_page(24'h001000, 1, 1, 0);
    run_xfer("t7", 24'h000FFF, 24'd2, -1, -1);
    compare("t7", lb, fb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
